// File: rtl/fpu_unbox_pipe_pkg.sv
// Shared configuration for the FP operand unbox pipeline (FLEN=64, D and S
// formats). Format encoding: 0 = single, 1 = double; any other code is
// handled as double, the widest supported format.
package fpu_unbox_pipe_pkg;

    localparam int D_LEN   = 64;
    localparam int S_LEN   = 32;
    localparam int LEN1    = D_LEN;
    localparam int LEN2    = S_LEN;
    localparam int FLEN    = LEN1;
    localparam int FPSIZES = 2;
    localparam int FMTBITS = 2;
    localparam int NE      = 11;
    localparam int NF      = 52;
    localparam int S_FRAC  = 23;

    localparam logic [FMTBITS-1:0] FMT_S = 2'd0;
    localparam logic [FMTBITS-1:0] FMT_D = 2'd1;

    // Exponent biases, already widened to the widest exponent width.
    localparam logic [NE-1:0] BIAS_S = 11'd127;
    localparam logic [NE-1:0] BIAS_D = 11'd1023;

    // Canonical quiet NaN substituted for a badly boxed single.
    localparam logic [LEN2-1:0] CNAN_S = 32'h7FC0_0000;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
        logic subnorm;
        logic boxerr;
    } unbox_flags_t;

    typedef struct packed {
        logic         xs;
        logic [NE-1:0] xe;
        logic [NF-1:0] xm;
        unbox_flags_t  flags;
    } unbox_t;

endpackage

// File: rtl/fpu_unbox_pipe_if.sv
// Handshake bundles for the unbox pipeline: operand side and result side.
// With FPU_UNBOX_CLASS_EN defined the result side also carries the fclass
// one-hot vector.
interface fpu_unbox_op_if import fpu_unbox_pipe_pkg::*; #(parameter int TAGW = 5);
    logic               in_valid;
    logic               in_ready;
    logic [FLEN-1:0]    X;
    logic [FMTBITS-1:0] Fmt;
    logic [TAGW-1:0]    in_tag;

    modport master (output in_valid, X, Fmt, in_tag, input in_ready);
    modport slave  (input in_valid, X, Fmt, in_tag, output in_ready);
endinterface

interface fpu_unbox_res_if import fpu_unbox_pipe_pkg::*; #(parameter int TAGW = 5);
    logic            out_valid;
    logic            out_ready;
    logic            Xs;
    logic [NE-1:0]   Xe;
    logic [NF-1:0]   Xm;
    logic            XNaN;
    logic            XSNaN;
    logic            XInf;
    logic            XZero;
    logic            XSubnorm;
    logic            XBoxErr;
    logic [TAGW-1:0] out_tag;
`ifdef FPU_UNBOX_CLASS_EN
    logic [9:0]      Class;
`endif

    modport master (
        output out_valid, Xs, Xe, Xm, XNaN, XSNaN, XInf, XZero, XSubnorm, XBoxErr, out_tag,
`ifdef FPU_UNBOX_CLASS_EN
        output Class,
`endif
        input  out_ready
    );
    modport slave (
        input  out_valid, Xs, Xe, Xm, XNaN, XSNaN, XInf, XZero, XSubnorm, XBoxErr, out_tag,
`ifdef FPU_UNBOX_CLASS_EN
        input  Class,
`endif
        output out_ready
    );
endinterface

// File: rtl/fpu_unbox_decode.sv
// Combinational operand unpacker: NaN-box check, rebias to the widest
// exponent, left-aligned fraction and classification. FPU_UNBOX_CLASS_EN
// adds the RISC-V fclass one-hot output.
module fpu_unbox_decode
    import fpu_unbox_pipe_pkg::*;
(
    input  logic [FLEN-1:0]    i_x,
    input  logic [FMTBITS-1:0] i_fmt,
    output unbox_t             o_res
`ifdef FPU_UNBOX_CLASS_EN
    ,
    output logic [9:0]         o_class
`endif
);

    logic            w_boxerr;
    logic [LEN2-1:0] w_sx;
    logic            w_sign;
    logic [NE-1:0]   w_e;
    logic            w_e_zero;
    logic            w_e_max;
    logic [NF-1:0]   w_frac;
    logic [NE-1:0]   w_bias;
    logic            w_frac_nz;

    // Select the format's fields, substituting the canonical NaN on a box error.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        w_boxerr = 1'b0;
        w_sx     = '0;
        w_sign   = i_x[FLEN-1];
        w_e      = i_x[FLEN-2 -: NE];
        w_e_zero = ~|i_x[FLEN-2 -: NE];
        w_e_max  = &i_x[FLEN-2 -: NE];
        w_frac   = i_x[NF-1:0];
        w_bias   = BIAS_D;
        if (i_fmt == FMT_S) begin
            w_boxerr = (FPSIZES > 1) && !(&i_x[FLEN-1:LEN2]);
            w_sx     = w_boxerr ? CNAN_S : i_x[LEN2-1:0];
            w_sign   = w_sx[31];
            w_e      = NE'(w_sx[30:23]);
            w_e_zero = ~|w_sx[30:23];
            w_e_max  = &w_sx[30:23];
            w_frac   = {w_sx[S_FRAC-1:0], {(NF-S_FRAC){1'b0}}};
            w_bias   = BIAS_S;
        end
    end

    // Rebias the exponent (subnormals use E=1) and derive the class flags.
    always_comb begin
        w_frac_nz           = |w_frac;
        o_res               = '0;
        o_res.xs            = w_sign;
        o_res.xe            = w_e_max ? {NE{1'b1}}
                                      : ((w_e_zero ? NE'(1) : w_e) - w_bias + BIAS_D);
        o_res.xm            = w_frac;
        o_res.flags.zero    = w_e_zero & ~w_frac_nz;
        o_res.flags.subnorm = w_e_zero & w_frac_nz;
        o_res.flags.inf     = w_e_max & ~w_frac_nz;
        o_res.flags.nan     = w_e_max & w_frac_nz;
        o_res.flags.snan    = w_e_max & w_frac_nz & ~w_frac[NF-1];
        o_res.flags.boxerr  = w_boxerr;
    end

`ifdef FPU_UNBOX_CLASS_EN
    // fclass one-hot: bit 0 = -inf ... bit 7 = +inf, bit 8 = sNaN, bit 9 = qNaN.
    always_comb begin
        o_class = '0;
        if (o_res.flags.nan)          o_class[o_res.flags.snan ? 8 : 9] = 1'b1;
        else if (o_res.flags.inf)     o_class[w_sign ? 0 : 7] = 1'b1;
        else if (o_res.flags.zero)    o_class[w_sign ? 3 : 4] = 1'b1;
        else if (o_res.flags.subnorm) o_class[w_sign ? 2 : 5] = 1'b1;
        else                          o_class[w_sign ? 1 : 6] = 1'b1;
    end
`endif

endmodule

// File: rtl/fpu_unbox_pipe.sv
// Two-stage elastic unbox pipeline between FP operand read and execute.
// Stage 1 registers the decoded operand, stage 2 is the output register.
// FPU_UNBOX_CLASS_EN adds the Class output, piped alongside the data.
module fpu_unbox_pipe
    import fpu_unbox_pipe_pkg::*;
#(
    parameter int TAGW = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    fpu_unbox_op_if.slave    in_if,
    fpu_unbox_res_if.master  out_if
);

    unbox_t          w_dec;
    logic            w_s2_load;
    logic            w_s1_adv;
    logic            w_in_ready;
    logic            w_accept;

    logic            r_s1_valid;
    unbox_t          r_s1_res;
    logic [TAGW-1:0] r_s1_tag;
    logic            r_s2_valid;
    unbox_t          r_s2_res;
    logic [TAGW-1:0] r_s2_tag;

`ifdef FPU_UNBOX_CLASS_EN
    logic [9:0]      w_class;
    logic [9:0]      r_s1_class;
    logic [9:0]      r_s2_class;
`endif

    fpu_unbox_decode u_decode (
        .i_x     (in_if.X),
        .i_fmt   (in_if.Fmt),
        .o_res   (w_dec)
`ifdef FPU_UNBOX_CLASS_EN
        ,
        .o_class (w_class)
`endif
    );

    // A stage moves forward when its successor is empty or draining; flush blocks intake.
    assign w_s2_load   = ~r_s2_valid | out_if.out_ready;
    assign w_s1_adv    = r_s1_valid & w_s2_load;
    assign w_in_ready  = ~flush & (~r_s1_valid | w_s1_adv);
    assign w_accept    = in_if.in_valid & w_in_ready;
    assign in_if.in_ready = w_in_ready;

    // Stage registers: reset and flush clear the valids, data moves on transfer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) begin
            // NOTE: data registers are reset too because the outputs must read 0 after reset.
            r_s1_valid <= 1'b0;
            r_s1_res   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept | (r_s1_valid & ~w_s1_adv);
            r_s2_valid <= w_s1_adv | (r_s2_valid & ~out_if.out_ready);
            if (w_accept) begin
                r_s1_res <= w_dec;
                r_s1_tag <= in_if.in_tag;
            end
            if (w_s1_adv) begin
                r_s2_res <= r_s1_res;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

`ifdef FPU_UNBOX_CLASS_EN
    // Class vector follows the same transfers as the data it describes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_class <= '0;
            r_s2_class <= '0;
        end else if (!flush) begin
            if (w_accept) r_s1_class <= w_class;
            if (w_s1_adv) r_s2_class <= r_s1_class;
        end
    end
    assign out_if.Class = r_s2_class;
`endif

    assign out_if.out_valid = r_s2_valid;
    assign out_if.Xs        = r_s2_res.xs;
    assign out_if.Xe        = r_s2_res.xe;
    assign out_if.Xm        = r_s2_res.xm;
    assign out_if.XNaN      = r_s2_res.flags.nan;
    assign out_if.XSNaN     = r_s2_res.flags.snan;
    assign out_if.XInf      = r_s2_res.flags.inf;
    assign out_if.XZero     = r_s2_res.flags.zero;
    assign out_if.XSubnorm  = r_s2_res.flags.subnorm;
    assign out_if.XBoxErr   = r_s2_res.flags.boxerr;
    assign out_if.out_tag   = r_s2_tag;

endmodule

// File: tb/tb_fpu_unbox_pipe.sv
// Self-checking bench for fpu_unbox_pipe: directed vector table, stall,
// flush and reset sequences, then randomized traffic against a reference model.
module tb_fpu_unbox_pipe;
    import fpu_unbox_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    fpu_unbox_op_if  #(.TAGW(5)) op_if ();
    fpu_unbox_res_if #(.TAGW(5)) res_if ();

    fpu_unbox_pipe #(.TAGW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .in_if   (op_if),
        .out_if  (res_if)
    );

    typedef struct {
        unbox_t     res;
        logic [4:0] tag;
        logic [9:0] cls;
    } exp_t;

    typedef struct {
        logic [63:0] x;
        logic [1:0]  fmt;
        logic [4:0]  tag;
        exp_t        e;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];
    logic [4:0] out_tags[$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model computed from the format rules with plain arithmetic.
    function automatic exp_t model(input logic [63:0] x, input logic [1:0] fmt, input logic [4:0] tag);
        exp_t r;
        int ebits, fbits, bias, v;
        logic [63:0] e, f, emax;
        logic s;
        r.tag = tag;
        r.res = '0;
        r.cls = '0;
        if (fmt == 2'd0) begin
            ebits = 8; fbits = 23; bias = 127;
            if (x[63:32] != 32'hFFFF_FFFF) begin
                r.res.xe = 11'h7FF;
                r.res.xm = 52'h8_0000_0000_0000;
                r.res.flags.nan = 1'b1;
                r.res.flags.boxerr = 1'b1;
                r.cls = 10'h200;
                return r;
            end
            s = x[31];
            e = (x >> 23) & 64'hFF;
            f = x & ((64'd1 << 23) - 1);
        end else begin
            ebits = 11; fbits = 52; bias = 1023;
            s = x[63];
            e = (x >> 52) & 64'h7FF;
            f = x & ((64'd1 << 52) - 1);
        end
        emax = (64'd1 << ebits) - 1;
        v = ((e == 0) ? 1 : int'(e)) - bias + 1023;
        r.res.xs = s;
        r.res.xe = (e == emax) ? 11'h7FF : 11'(v);
        r.res.xm = 52'(f << (52 - fbits));
        r.res.flags.zero    = (e == 0) && (f == 0);
        r.res.flags.subnorm = (e == 0) && (f != 0);
        r.res.flags.inf     = (e == emax) && (f == 0);
        r.res.flags.nan     = (e == emax) && (f != 0);
        r.res.flags.snan    = r.res.flags.nan && (((f >> (fbits - 1)) & 1) == 0);
        if (r.res.flags.nan)          r.cls = r.res.flags.snan ? 10'h100 : 10'h200;
        else if (r.res.flags.inf)     r.cls = s ? 10'h001 : 10'h080;
        else if (r.res.flags.zero)    r.cls = s ? 10'h008 : 10'h010;
        else if (r.res.flags.subnorm) r.cls = s ? 10'h004 : 10'h020;
        else                          r.cls = s ? 10'h002 : 10'h040;
        return r;
    endfunction

    function automatic unbox_t dut_res();
        unbox_t r;
        r.xs = res_if.Xs;
        r.xe = res_if.Xe;
        r.xm = res_if.Xm;
        r.flags.nan = res_if.XNaN;
        r.flags.snan = res_if.XSNaN;
        r.flags.inf = res_if.XInf;
        r.flags.zero = res_if.XZero;
        r.flags.subnorm = res_if.XSubnorm;
        r.flags.boxerr = res_if.XBoxErr;
        return r;
    endfunction

    function automatic logic [9:0] dut_cls();
`ifdef FPU_UNBOX_CLASS_EN
        return res_if.Class;
`else
        return 10'h0;
`endif
    endfunction

    // Scoreboard monitor: records accepts, compares transfers, checks stall stability.
    bit         stalled = 1'b0;
    unbox_t     held_res;
    logic [4:0] held_tag;
    logic [9:0] held_cls;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n || flush) begin
                sb.delete();
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("stall_hold", {res_if.out_valid, dut_res(), res_if.out_tag, dut_cls()},
                          {1'b1, held_res, held_tag, held_cls});
                if (res_if.out_valid) begin
                    check("sb_has_entry", sb.size() != 0, 1);
                    if (res_if.out_ready && sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_res", dut_res(), e.res);
                        check("sb_tag", res_if.out_tag, e.tag);
`ifdef FPU_UNBOX_CLASS_EN
                        check("sb_class", dut_cls(), e.cls);
`endif
                        out_tags.push_back(res_if.out_tag);
                    end
                end
                stalled  = res_if.out_valid && !res_if.out_ready;
                held_res = dut_res();
                held_tag = res_if.out_tag;
                held_cls = dut_cls();
                if (op_if.in_valid && op_if.in_ready)
                    sb.push_back(model(op_if.X, op_if.Fmt, op_if.in_tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_x(input logic [1:0] fmt);
        logic [63:0] x;
        int k;
        x = {$urandom, $urandom};
        k = $urandom_range(0, 7);
        if (fmt == 2'd0) begin
            if (k == 0) x[30:23] = '0;
            if (k == 1) x[30:23] = '1;
            if (k == 2) x[22:0] = '0;
            if (k == 3) begin x[30:23] = '0; x[22:0] = '0; end
            if (k == 4) begin x[30:23] = '1; x[22:0] = '0; end
            if ($urandom_range(0, 4) != 0) x[63:32] = '1;
        end else begin
            if (k == 0) x[62:52] = '0;
            if (k == 1) x[62:52] = '1;
            if (k == 2) x[51:0] = '0;
            if (k == 3) begin x[62:52] = '0; x[51:0] = '0; end
            if (k == 4) begin x[62:52] = '1; x[51:0] = '0; end
        end
        return x;
    endfunction

    function automatic vec_t mk(input logic [63:0] x, input logic [1:0] fmt, input logic s,
                                input logic [10:0] e, input logic [51:0] m, input logic [5:0] fl,
                                input logic [9:0] cls);
        vec_t v;
        v.x = x; v.fmt = fmt; v.tag = 5'(x[4:0] ^ 5'h15);
        v.e.res.xs = s; v.e.res.xe = e; v.e.res.xm = m; v.e.res.flags = fl;
        v.e.tag = v.tag; v.e.cls = cls;
        return v;
    endfunction

    vec_t vecs[$];
    int sent, first_block, acc, lat, got, any_out;

    initial begin
        // flags order: nan snan inf zero subnorm boxerr
        vecs.push_back(mk(64'hFFFFFFFF_3F800000, 2'd0, 0, 11'h3FF, 52'h0, 6'b000000, 10'h040));
        vecs.push_back(mk(64'h00000000_3F800000, 2'd0, 0, 11'h7FF, 52'h8000000000000, 6'b100001, 10'h200));
        vecs.push_back(mk(64'hFFFFFFFF_00000001, 2'd0, 0, 11'h381, 52'h0000020000000, 6'b000010, 10'h020));
        vecs.push_back(mk(64'hFFF0000000000000, 2'd1, 1, 11'h7FF, 52'h0, 6'b001000, 10'h001));
        vecs.push_back(mk(64'hFFFFFFFF_7F800001, 2'd0, 0, 11'h7FF, 52'h0000020000000, 6'b110000, 10'h100));
        vecs.push_back(mk(64'h0000000000000000, 2'd1, 0, 11'h001, 52'h0, 6'b000100, 10'h010));
        vecs.push_back(mk(64'h8000000000000001, 2'd1, 1, 11'h001, 52'h1, 6'b000010, 10'h004));
        vecs.push_back(mk(64'hFFFFFFFF_C0490FDB, 2'd0, 1, 11'h400, 52'h921FB60000000, 6'b000000, 10'h002));
        vecs.push_back(mk(64'h3FF0000000000000, 2'd2, 0, 11'h3FF, 52'h0, 6'b000000, 10'h040));
        vecs.push_back(mk(64'h7FFFFFFF_3F800000, 2'd0, 0, 11'h7FF, 52'h8000000000000, 6'b100001, 10'h200));
        vecs.push_back(mk(64'hFFFFFFFF_7F800000, 2'd0, 0, 11'h7FF, 52'h0, 6'b001000, 10'h080));
        vecs.push_back(mk(64'h7FF8000000000000, 2'd1, 0, 11'h7FF, 52'h8000000000000, 6'b100000, 10'h200));

        op_if.in_valid = 0; op_if.X = '0; op_if.Fmt = '0; op_if.in_tag = '0;
        res_if.out_ready = 1;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", res_if.out_valid, 0);
        check("reset_data", {dut_res(), res_if.out_tag, dut_cls()}, '0);
        check("reset_in_ready", op_if.in_ready, 1);
        mon_en = 1'b1;
        tick();

        // Directed vectors, one at a time, with latency check.
        foreach (vecs[i]) begin
            op_if.in_valid = 1; op_if.X = vecs[i].x; op_if.Fmt = vecs[i].fmt; op_if.in_tag = vecs[i].tag;
            acc = 0;
            for (int c = 0; c < 8 && !acc; c++) begin
                @(negedge clk);
                acc = op_if.in_ready;
                tick();
            end
            check($sformatf("vec%0d_accept", i), acc, 1);
            op_if.in_valid = 0;
            got = 0; lat = 0;
            for (int c = 1; c <= 6 && !got; c++) begin
                @(negedge clk);
                if (res_if.out_valid) begin got = 1; lat = c; end
            end
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_res", i), dut_res(), vecs[i].e.res);
            check($sformatf("vec%0d_tag", i), res_if.out_tag, vecs[i].e.tag);
`ifdef FPU_UNBOX_CLASS_EN
            check($sformatf("vec%0d_class", i), dut_cls(), vecs[i].e.cls);
`endif
            tick();
        end
        repeat (3) tick();

        // Back-to-back ops into a stalled consumer.
        res_if.out_ready = 0; sent = 0; first_block = -1;
        out_tags.delete();
        for (int c = 0; c < 20; c++) begin
            if (c == 6) res_if.out_ready = 1;
            op_if.in_valid = (sent < 4);
            op_if.X = {32'hFFFF_FFFF, $urandom};
            op_if.Fmt = 2'd0;
            op_if.in_tag = 5'(10 + sent);
            @(negedge clk);
            if (op_if.in_valid && !op_if.in_ready && first_block < 0) first_block = sent;
            if (op_if.in_valid && op_if.in_ready) sent++;
            tick();
        end
        op_if.in_valid = 0;
        check("stall_block_after", first_block, 2);
        check("stall_all_sent", sent, 4);
        check("stall_out_count", out_tags.size(), 4);
        for (int i = 0; i < 4 && i < out_tags.size(); i++)
            check($sformatf("stall_order%0d", i), out_tags[i], 5'(10 + i));

        // Flush with two entries in flight and an input offered.
        res_if.out_ready = 0;
        op_if.in_valid = 1; op_if.Fmt = 2'd1;
        for (int c = 0; c < 2; c++) begin
            op_if.X = rand_x(2'd1); op_if.in_tag = 5'(20 + c);
            tick();
        end
        flush = 1; op_if.in_tag = 5'd22;
        @(negedge clk);
        check("flush_pre_out_valid", res_if.out_valid, 1);
        check("flush_in_ready", op_if.in_ready, 0);
        tick();
        flush = 0; op_if.in_valid = 0; res_if.out_ready = 1;
        any_out = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_if.out_valid) any_out = 1;
        end
        check("flush_no_output", any_out, 0);
        tick();

        // Reset mid-operation.
        res_if.out_ready = 0;
        op_if.in_valid = 1; op_if.Fmt = 2'd0;
        for (int c = 0; c < 2; c++) begin
            op_if.X = rand_x(2'd0); op_if.in_tag = 5'(24 + c);
            tick();
        end
        op_if.in_valid = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        @(negedge clk);
        check("midreset_out_valid", res_if.out_valid, 0);
        check("midreset_data", {dut_res(), res_if.out_tag}, '0);
        check("midreset_in_ready", op_if.in_ready, 1);
        res_if.out_ready = 1;
        any_out = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_if.out_valid) any_out = 1;
        end
        check("midreset_no_pulse", any_out, 0);
        tick();

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 600; c++) begin
            op_if.in_valid = ($urandom_range(0, 3) != 0);
            res_if.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            op_if.Fmt = 2'($urandom_range(0, 3));
            op_if.X = rand_x(op_if.Fmt);
            op_if.in_tag = 5'($urandom);
            tick();
        end
        op_if.in_valid = 0; flush = 0; res_if.out_ready = 1;
        repeat (6) tick();
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
